// File: rtl/pitch_unit_encoder.sv
// BATS PITCH sequenced-unit builder: one command in, one unit (8-byte header + one message)
// out as 64-bit little-endian words with byte enables and valid/ready handshake.
module pitch_unit_encoder #(
    parameter logic [7:0]  UNIT     = 8'd1,
    parameter logic [31:0] INIT_SEQ = 32'd2
) (
    input  logic        Clk40,
    input  logic        reset_n,
    input  logic        sync_clear,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_type,
    input  logic [31:0] cmd_seconds,
    input  logic [31:0] cmd_time_offset,
    input  logic [63:0] cmd_order_id,
    input  logic [7:0]  cmd_side,
    input  logic [15:0] cmd_quantity,
    input  logic [47:0] cmd_symbol,
    input  logic [15:0] cmd_price,
    input  logic [7:0]  cmd_flags,
    output logic        out_data_valid,
    output logic [7:0]  out_byte_enables,
    output logic [63:0] out_bytes,
    output logic        out_last,
    input  logic        out_ready,
    output logic        err_bad_type
);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t              r_state;
    logic [31:0]         r_seq;
    logic [39:0][7:0]    r_buf;
    logic [2:0]          r_idx;
    logic [2:0]          r_nwords;
    logic [7:0]          r_last_be;
    logic                r_cmd_ready;
    logic                r_valid;
    logic [7:0]          r_be;
    logic [63:0]         r_bytes;
    logic                r_last;
    logic                r_err;

    logic [39:0][7:0]    w_unit;
    logic [7:0]          w_len;
    logic [2:0]          w_nwords;
    logic [7:0]          w_last_be;
    logic                w_type_ok;
    logic [5:0]          w_base;
    logic                w_next_last;

    // Whole unit is assembled from the live command fields; bytes past the unit stay 0
    // so unused lanes of the last word are naturally zero.
    always_comb begin
        w_unit    = '0;
        w_len     = 8'd0;
        w_nwords  = 3'd0;
        w_last_be = 8'h00;
        w_type_ok = 1'b1;
        case (cmd_type)
            8'h20: begin
                w_len = 8'd14; w_nwords = 3'd2; w_last_be = 8'h3F;
                w_unit[8] = 8'd6;
                w_unit[9] = 8'h20;
                for (int i = 0; i < 4; i++) w_unit[10+i] = cmd_seconds[8*i +: 8];
            end
            8'h29: begin
                w_len = 8'd22; w_nwords = 3'd3; w_last_be = 8'h3F;
                w_unit[8] = 8'd14;
                w_unit[9] = 8'h29;
                for (int i = 0; i < 4; i++) w_unit[10+i] = cmd_time_offset[8*i +: 8];
                for (int i = 0; i < 8; i++) w_unit[14+i] = cmd_order_id[8*i +: 8];
            end
            8'h22: begin
                w_len = 8'd34; w_nwords = 3'd5; w_last_be = 8'h03;
                w_unit[8] = 8'd26;
                w_unit[9] = 8'h22;
                for (int i = 0; i < 4; i++) w_unit[10+i] = cmd_time_offset[8*i +: 8];
                for (int i = 0; i < 8; i++) w_unit[14+i] = cmd_order_id[8*i +: 8];
                w_unit[22] = cmd_side;
                for (int i = 0; i < 2; i++) w_unit[23+i] = cmd_quantity[8*i +: 8];
                for (int i = 0; i < 6; i++) w_unit[25+i] = cmd_symbol[8*i +: 8];
                for (int i = 0; i < 2; i++) w_unit[31+i] = cmd_price[8*i +: 8];
                w_unit[33] = cmd_flags;
            end
            default: w_type_ok = 1'b0;
        endcase
        w_unit[0] = w_len;
        w_unit[1] = 8'd0;
        w_unit[2] = 8'd1;
        w_unit[3] = UNIT;
        for (int i = 0; i < 4; i++) w_unit[4+i] = r_seq[8*i +: 8];
    end

    assign w_base      = {r_idx, 3'b000};
    assign w_next_last = (r_idx == r_nwords - 3'd1);

    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_seq       <= INIT_SEQ;
            r_buf       <= '0;
            r_idx       <= 3'd0;
            r_nwords    <= 3'd0;
            r_last_be   <= 8'h00;
            r_cmd_ready <= 1'b1;
            r_valid     <= 1'b0;
            r_be        <= 8'h00;
            r_bytes     <= 64'd0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
        end else if (sync_clear) begin
            r_state     <= S_IDLE;
            r_seq       <= INIT_SEQ;
            r_idx       <= 3'd0;
            r_cmd_ready <= 1'b1;
            r_valid     <= 1'b0;
            r_be        <= 8'h00;
            r_bytes     <= 64'd0;
            r_last      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_type_ok) begin
                            r_buf       <= w_unit;
                            r_nwords    <= w_nwords;
                            r_last_be   <= w_last_be;
                            r_idx       <= 3'd1;
                            r_bytes     <= w_unit[7:0];
                            r_be        <= 8'hFF;
                            r_last      <= 1'b0;
                            r_valid     <= 1'b1;
                            r_cmd_ready <= 1'b0;
                            r_state     <= S_SEND;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_last) begin
                            r_valid     <= 1'b0;
                            r_bytes     <= 64'd0;
                            r_be        <= 8'h00;
                            r_last      <= 1'b0;
                            r_seq       <= r_seq + 32'd1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_bytes <= r_buf[w_base +: 8];
                            r_last  <= w_next_last;
                            r_be    <= w_next_last ? r_last_be : 8'hFF;
                            r_idx   <= r_idx + 3'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready        = r_cmd_ready;
    assign out_data_valid   = r_valid;
    assign out_byte_enables = r_be;
    assign out_bytes        = r_bytes;
    assign out_last         = r_last;
    assign err_bad_type     = r_err;

endmodule

// File: tb/tb_pitch_unit_encoder.sv
// Scoreboard bench: a byte-list reference model queues expected words on issue; a negedge
// monitor pops and compares on every transfer and checks stability under backpressure.
module tb_pitch_unit_encoder;

    localparam logic [7:0]  UNIT     = 8'd1;
    localparam logic [31:0] INIT_SEQ = 32'd2;

    logic        Clk40, reset_n, sync_clear, cmd_valid, cmd_ready;
    logic [7:0]  cmd_type, cmd_side, cmd_flags;
    logic [31:0] cmd_seconds, cmd_time_offset;
    logic [63:0] cmd_order_id;
    logic [15:0] cmd_quantity, cmd_price;
    logic [47:0] cmd_symbol;
    logic        out_data_valid, out_last, out_ready, err_bad_type;
    logic [7:0]  out_byte_enables;
    logic [63:0] out_bytes;

    pitch_unit_encoder #(.UNIT(UNIT), .INIT_SEQ(INIT_SEQ)) dut (
        .Clk40(Clk40), .reset_n(reset_n), .sync_clear(sync_clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_seconds(cmd_seconds), .cmd_time_offset(cmd_time_offset),
        .cmd_order_id(cmd_order_id), .cmd_side(cmd_side), .cmd_quantity(cmd_quantity),
        .cmd_symbol(cmd_symbol), .cmd_price(cmd_price), .cmd_flags(cmd_flags),
        .out_data_valid(out_data_valid), .out_byte_enables(out_byte_enables),
        .out_bytes(out_bytes), .out_last(out_last), .out_ready(out_ready),
        .err_bad_type(err_bad_type)
    );

    typedef struct {
        logic [7:0]  typ;
        logic [31:0] sec;
        logic [31:0] off;
        logic [63:0] id;
        logic [7:0]  side;
        logic [15:0] qty;
        logic [47:0] sym;
        logic [15:0] price;
        logic [7:0]  flags;
    } cmd_t;

    typedef struct {
        logic [63:0] bytes;
        logic [7:0]  be;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    logic [7:0]  ub[$];
    logic [31:0] model_seq;
    int          errors = 0;
    int          checks = 0;
    int          pops   = 0;
    bit          stall_en = 0;

    logic        st_vld = 0;
    logic [63:0] st_bytes;
    logic [7:0]  st_be;
    logic        st_last;

    initial begin
        Clk40 = 0;
        forever #5 Clk40 = ~Clk40;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_le(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) ub.push_back(v[8*i +: 8]);
    endtask

    // Reference: lay the unit out as a plain byte list, then chop it into 8-byte words.
    task automatic model_unit(input cmd_t c, input logic [31:0] seq);
        int    ml;
        int    n;
        word_t w;
        ub.delete();
        ml = (c.typ == 8'h20) ? 6 : (c.typ == 8'h29) ? 14 : 26;
        push_le(64'(ml + 8), 2);
        push_le(64'd1, 1);
        push_le(64'(UNIT), 1);
        push_le(64'(seq), 4);
        push_le(64'(ml), 1);
        push_le(64'(c.typ), 1);
        if (c.typ == 8'h20) begin
            push_le(64'(c.sec), 4);
        end else begin
            push_le(64'(c.off), 4);
            push_le(c.id, 8);
            if (c.typ == 8'h22) begin
                push_le(64'(c.side), 1);
                push_le(64'(c.qty), 2);
                push_le(64'(c.sym), 6);
                push_le(64'(c.price), 2);
                push_le(64'(c.flags), 1);
            end
        end
        n = (ub.size() + 7) / 8;
        for (int k = 0; k < n; k++) begin
            w.bytes = '0;
            w.be    = '0;
            for (int l = 0; l < 8; l++) begin
                if (k*8 + l < ub.size()) begin
                    w.bytes[8*l +: 8] = ub[k*8 + l];
                    w.be[l] = 1'b1;
                end
            end
            w.last = (k == n - 1);
            exp_q.push_back(w);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        case ($urandom_range(0, 2))
            0:       c.typ = 8'h20;
            1:       c.typ = 8'h29;
            default: c.typ = 8'h22;
        endcase
        c.sec   = $urandom;
        c.off   = $urandom;
        c.id    = {$urandom, $urandom};
        c.side  = $urandom_range(0, 1) ? 8'h42 : 8'h53;
        c.qty   = 16'($urandom);
        c.sym   = {16'($urandom), $urandom};
        c.price = 16'($urandom);
        c.flags = 8'($urandom);
        return c;
    endfunction

    task automatic drive(input cmd_t c);
        cmd_type        = c.typ;
        cmd_seconds     = c.sec;
        cmd_time_offset = c.off;
        cmd_order_id    = c.id;
        cmd_side        = c.side;
        cmd_quantity    = c.qty;
        cmd_symbol      = c.sym;
        cmd_price       = c.price;
        cmd_flags       = c.flags;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input cmd_t c);
        bit good;
        good = (c.typ == 8'h20) || (c.typ == 8'h29) || (c.typ == 8'h22);
        for (int k = 0; k < 2000 && !cmd_ready; k++) begin
            @(posedge Clk40); #1;
        end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        drive(c);
        if (good) begin
            model_unit(c, model_seq);
            model_seq = model_seq + 32'd1;
        end
        cmd_valid = 1;
        @(posedge Clk40); #1;
        cmd_valid = 0;
        drive(rand_cmd());
        if (good) begin
            chk("first_word_latency", out_data_valid, 1'b1);
            chk("cmd_ready_busy", cmd_ready, 1'b0);
        end else begin
            chk("err_pulse", err_bad_type, 1'b1);
            chk("bad_no_output", out_data_valid, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 2000 && (exp_q.size() != 0 || !cmd_ready); k++) begin
            @(posedge Clk40); #1;
        end
        chk("drain_timeout", 64'(k < 2000), 64'd1);
    endtask

    task automatic wait_word1();
        int target;
        int k;
        target = pops + 1;
        for (k = 0; k < 200 && pops < target; k++) begin
            @(posedge Clk40); #1;
        end
        chk("mid_frame_reach", 64'(pops >= target), 64'd1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, out_data_valid, 1'b0);
        chk({tag, "_bytes"}, out_bytes, 64'd0);
        chk({tag, "_be"}, out_byte_enables, 8'h00);
        chk({tag, "_last"}, out_last, 1'b0);
        chk({tag, "_err"}, err_bad_type, 1'b0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    initial begin
        out_ready = 1;
        forever begin
            @(posedge Clk40); #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge Clk40) begin
        word_t e;
        if (st_vld && reset_n) begin
            chk("stall_valid", out_data_valid, 1'b1);
            chk("stall_bytes", out_bytes, st_bytes);
            chk("stall_be", out_byte_enables, st_be);
            chk("stall_last", out_last, st_last);
        end
        st_vld   = out_data_valid && !out_ready && reset_n && !sync_clear;
        st_bytes = out_bytes;
        st_be    = out_byte_enables;
        st_last  = out_last;
        if (out_data_valid && out_ready && reset_n && !sync_clear) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", out_bytes, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("word_bytes", out_bytes, e.bytes);
                chk("word_be", out_byte_enables, e.be);
                chk("word_last", out_last, e.last);
                pops++;
            end
        end
    end

    initial begin
        cmd_t c;
        model_seq  = INIT_SEQ;
        reset_n    = 0;
        sync_clear = 0;
        cmd_valid  = 0;
        drive(rand_cmd());
        repeat (3) @(posedge Clk40);
        #1;
        chk_quiet("in_reset");
        reset_n = 1;
        @(posedge Clk40); #1;
        chk_quiet("after_reset");

        c = rand_cmd();
        c.typ = 8'h20; c.sec = 32'h0006D219;
        issue(c);
        wait_idle();

        c = rand_cmd();
        c.typ = 8'h29; c.off = 32'h11223344; c.id = 64'h0102030405060708;
        issue(c);
        wait_idle();

        c = rand_cmd();
        c.typ = 8'h22; c.side = 8'h42; c.qty = 16'd100; c.sym = 48'h2020204C5041;
        c.price = 16'h1234; c.flags = 8'h01;
        issue(c);
        wait_idle();

        stall_en = 1;
        for (int n = 0; n < 20; n++) issue(rand_cmd());
        wait_idle();
        stall_en = 0;

        c = rand_cmd();
        c.typ = 8'h55;
        issue(c);
        @(posedge Clk40); #1;
        chk("err_one_cycle", err_bad_type, 1'b0);
        c = rand_cmd();
        c.typ = 8'h20;
        issue(c);
        wait_idle();

        @(posedge Clk40); #1;
        c = rand_cmd();
        c.typ = 8'h22;
        issue(c);
        wait_word1();
        reset_n = 0;
        #1;
        chk_quiet("async_reset");
        exp_q.delete();
        model_seq = INIT_SEQ;
        @(posedge Clk40); #1;
        reset_n = 1;
        @(posedge Clk40); #1;
        c = rand_cmd();
        c.typ = 8'h20;
        issue(c);
        wait_idle();

        c = rand_cmd();
        c.typ = 8'h22;
        issue(c);
        wait_idle();
        c = rand_cmd();
        c.typ = 8'h22;
        issue(c);
        wait_word1();
        sync_clear = 1;
        c = rand_cmd();
        c.typ = 8'h20;
        drive(c);
        cmd_valid = 1;
        @(posedge Clk40); #1;
        sync_clear = 0;
        cmd_valid  = 0;
        chk_quiet("sync_clear");
        exp_q.delete();
        model_seq = INIT_SEQ;
        @(posedge Clk40); #1;
        chk("clear_cmd_dropped", out_data_valid, 1'b0);
        c = rand_cmd();
        c.typ = 8'h20;
        issue(c);
        wait_idle();

        repeat (3) @(posedge Clk40);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
